// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared constants and encodings for the capture sequencer
package la_pkg;

    localparam int LA_ADDR_W    = 10;
    localparam int LA_DATA_W    = 8;
    localparam int LA_TIMEOUT_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ACQ     = 3'd2,
        ST_READOUT = 3'd3
    } state_e;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;
    localparam logic [1:0] TRIG_RSVD = 2'b11;

endpackage

// File: rtl/trig_detect.sv
// rtl/trig_detect.sv - level-crossing trigger detector on the live ADC stream
module trig_detect
    import la_pkg::*;
#(
    parameter int DATA_W = LA_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              armed,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] adc_data,
    output logic              trig_hit
);

    logic above;
    logic prev_above_q, prev_above_d;
    logic cond;

    always_comb begin
        above        = (adc_data >= trig_level);
        prev_above_d = above;
    end

    // History tracks every cycle so the first armed cycle already sees a valid edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_above_q <= 1'b0;
        end else begin
            prev_above_q <= prev_above_d;
        end
    end

    always_comb begin
        cond = 1'b1;
        case (trig_mode)
            TRIG_RISE: cond = ~prev_above_q & above;
            TRIG_FALL: cond = prev_above_q & ~above;
            default:   cond = 1'b1;
        endcase
        trig_hit = armed & cond;
    end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - capture FSM and sample RAM owner mux; AUTO_TRIG_EN adds trigger timeout
module capture_sequencer
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W,
    parameter int DATA_W = LA_DATA_W
`ifdef AUTO_TRIG_EN
    ,
    parameter int TIMEOUT_W = LA_TIMEOUT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              continuous,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] adc_data,
    output logic              grant_acq,
    input  logic              done_acq,
    input  logic [ADDR_W-1:0] acq_wr_addr,
    input  logic              acq_wr_en,
    output logic              grant_rd,
    input  logic              done_rd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              busy,
    output logic [2:0]        state_o,
    output logic              timed_out
);

    state_e state_q, state_d;
    logic   grant_acq_q, grant_acq_d;
    logic   grant_rd_q, grant_rd_d;
    logic   busy_q, busy_d;
    logic   acq_seen_q, acq_seen_d;
    logic   abort_lat_q, abort_lat_d;
    logic   timed_out_q, timed_out_d;
    logic   trig_hit;
    logic   force_trig;

    trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
        .clk        (clk),
        .rst        (rst),
        .armed      (state_q == ST_ARMED),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .adc_data   (adc_data),
        .trig_hit   (trig_hit)
    );

`ifdef AUTO_TRIG_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = (state_q == ST_ARMED) ? tmo_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign force_trig = (state_q == ST_ARMED) && (&tmo_cnt_q);
`else
    assign force_trig = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_acq_q <= 1'b0;
            grant_rd_q  <= 1'b0;
            busy_q      <= 1'b0;
            acq_seen_q  <= 1'b0;
            abort_lat_q <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_acq_q <= grant_acq_d;
            grant_rd_q  <= grant_rd_d;
            busy_q      <= busy_d;
            acq_seen_q  <= acq_seen_d;
            abort_lat_q <= abort_lat_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm && !abort) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort) state_d = ST_IDLE;
                else if (trig_hit || force_trig) state_d = ST_ACQ;
            end
            ST_ACQ: begin
                // The writer cannot be stopped mid-fill, so abort only redirects the exit
                if (acq_seen_q && done_acq) begin
                    state_d = (abort_lat_q || abort) ? ST_IDLE : ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (abort) state_d = ST_IDLE;
                else if (done_rd) state_d = continuous ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_acq_d = (state_q == ST_ARMED) && (state_d == ST_ACQ);
        grant_rd_d  = (state_d == ST_READOUT);
        busy_d      = (state_d != ST_IDLE);
        acq_seen_d  = (state_q == ST_ACQ) && (acq_seen_q || acq_wr_en);
        abort_lat_d = (state_q == ST_ACQ) && (abort_lat_q || abort);
`ifdef AUTO_TRIG_EN
        timed_out_d = timed_out_q;
        if ((state_q != ST_ARMED) && (state_d == ST_ARMED)) timed_out_d = 1'b0;
        else if (grant_acq_d && !trig_hit) timed_out_d = 1'b1;
`else
        timed_out_d = 1'b0;
`endif
    end

    always_comb begin
        ram_addr = '0;
        ram_wren = 1'b0;
        case (state_q)
            ST_ACQ: begin
                ram_addr = acq_wr_addr;
                ram_wren = acq_wr_en;
            end
            ST_READOUT: ram_addr = rd_addr;
            default: begin
                ram_addr = '0;
                ram_wren = 1'b0;
            end
        endcase
    end

    assign grant_acq = grant_acq_q;
    assign grant_rd  = grant_rd_q;
    assign busy      = busy_q;
    assign state_o   = state_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed and random bench for capture_sequencer against a reference model
module tb_capture_sequencer;

    localparam int AW = 10;
    localparam int DW = 8;
`ifdef AUTO_TRIG_EN
    localparam int TW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0, abort = 1'b0, continuous = 1'b0;
    logic [1:0]    trig_mode = 2'b00;
    logic [DW-1:0] trig_level = '0, adc_data = '0;
    logic          done_acq = 1'b0, acq_wr_en = 1'b0, done_rd = 1'b0;
    logic [AW-1:0] acq_wr_addr = '0, rd_addr = '0;
    logic          grant_acq, grant_rd, ram_wren, busy, timed_out;
    logic [AW-1:0] ram_addr;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    capture_sequencer #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef AUTO_TRIG_EN
        ,
        .TIMEOUT_W(TW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .continuous(continuous),
        .trig_mode(trig_mode), .trig_level(trig_level), .adc_data(adc_data),
        .grant_acq(grant_acq), .done_acq(done_acq), .acq_wr_addr(acq_wr_addr),
        .acq_wr_en(acq_wr_en), .grant_rd(grant_rd), .done_rd(done_rd), .rd_addr(rd_addr),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .busy(busy), .state_o(state_o),
        .timed_out(timed_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 armed, 2 acquiring, 3 readout
    int m_state;
    bit m_prev, m_seen, m_abort_pend, m_ga, m_grd, m_to;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_seen = 0; m_abort_pend = 0;
        m_ga = 0; m_grd = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit above, hit, forced;
        int nxt;
        above = (adc_data >= trig_level);
        case (trig_mode)
            2'b01:   hit = !m_prev && above;
            2'b10:   hit = m_prev && !above;
            default: hit = 1;
        endcase
        forced = 0;
`ifdef AUTO_TRIG_EN
        forced = (m_state == 1) && (m_cnt == (1 << TW) - 1);
`endif
        nxt = m_state;
        if (m_state == 0 && arm && !abort) nxt = 1;
        if (m_state == 1) nxt = abort ? 0 : ((hit || forced) ? 2 : 1);
        if (m_state == 2 && m_seen && done_acq) nxt = (m_abort_pend || abort) ? 0 : 3;
        if (m_state == 3) nxt = abort ? 0 : (done_rd ? (continuous ? 1 : 0) : 3);
        m_ga = (m_state == 1) && (nxt == 2);
`ifdef AUTO_TRIG_EN
        if (m_state != 1 && nxt == 1) m_to = 0;
        else if (m_ga && !hit) m_to = 1;
        m_cnt = (m_state == 1) ? ((m_cnt + 1) % (1 << TW)) : 0;
`endif
        m_seen       = (m_state == 2) && (m_seen || acq_wr_en);
        m_abort_pend = (m_state == 2) && (m_abort_pend || abort);
        m_prev       = above;
        m_grd        = (nxt == 3);
        m_state      = nxt;
    endtask

    task automatic check_all();
        logic [AW-1:0] exp_addr;
        exp_addr = (m_state == 2) ? acq_wr_addr : ((m_state == 3) ? rd_addr : '0);
        check("state", state_o, m_state);
        check("busy", busy, m_state != 0);
        check("grant_acq", grant_acq, m_ga);
        check("grant_rd", grant_rd, m_grd);
        check("ram_addr", ram_addr, exp_addr);
        check("ram_wren", ram_wren, (m_state == 2) && acq_wr_en);
        check("timed_out", timed_out, m_to);
    endtask

    task automatic step();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic finish_acq();
        acq_wr_addr = 10'h3FF; acq_wr_en = 1'b1;
        step();
        acq_wr_en = 1'b0; done_acq = 1'b1;
        step();
        done_acq = 1'b0;
    endtask

    initial begin
        int first_v;
        int waited;
        model_reset();
        step();
        step();
        check("reset_state", state_o, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Immediate trigger, stale done_acq ignored, readout to idle
        trig_mode = 2'b00; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("imm_grant", grant_acq, 1);
        acq_wr_addr = 10'h3FF; done_acq = 1'b1;
        repeat (3) step();
        check("stale_done_ignored", state_o, 2);
        done_acq = 1'b0;
        for (int a = 10'h3FA; a <= 10'h3FF; a++) begin
            acq_wr_addr = a[AW-1:0]; acq_wr_en = 1'b1;
            step();
        end
        acq_wr_en = 1'b0; done_acq = 1'b1;
        step();
        done_acq = 1'b0;
        check("done_to_readout", grant_rd, 1);
        repeat (4) begin
            rd_addr = AW'($urandom);
            step();
        end
        done_rd = 1'b1;
        step();
        done_rd = 1'b0;
        check("rd_done_idle", busy, 0);

        // Rising crossing on a ramp
        trig_mode = 2'b01; trig_level = 8'h80; adc_data = 8'h70; arm = 1'b1;
        step();
        arm = 1'b0;
        first_v = -1;
        for (int v = 8'h71; v <= 8'h90; v++) begin
            adc_data = v[DW-1:0];
            step();
            if (grant_acq === 1'b1 && first_v < 0) first_v = v;
        end
        check("rise_first_grant", first_v, 8'h80);
        finish_acq();
        done_rd = 1'b1;
        step();
        done_rd = 1'b0;

        // Already above when armed: 0x80 after 0x85 must not trigger
        adc_data = 8'h85; arm = 1'b1;
        step();
        arm = 1'b0; adc_data = 8'h80;
        repeat (3) step();
        check("rise_no_retrigger", state_o, 1);
        adc_data = 8'h10;
        step();
        adc_data = 8'h80;
        step();
        check("rise_grant", grant_acq, 1);

        // Abort during acquisition waits for done_acq
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_acq_holds", state_o, 2);
        finish_acq();
        check("abort_acq_idle", state_o, 0);

        // Falling crossing then abort during readout
        trig_mode = 2'b10; trig_level = 8'h40; adc_data = 8'h50; arm = 1'b1;
        step();
        arm = 1'b0; adc_data = 8'h30;
        step();
        check("fall_grant", grant_acq, 1);
        finish_acq();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_rd_drop", grant_rd, 0);

        // arm and abort together
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        check("arm_abort_idle", state_o, 0);

        // Continuous: three back-to-back captures
        continuous = 1'b1; trig_mode = 2'b00; arm = 1'b1;
        step();
        arm = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            finish_acq();
            step();
            done_rd = 1'b1;
            step();
            done_rd = 1'b0;
            check("cont_rearm", state_o, 1);
        end
        continuous = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;

`ifdef AUTO_TRIG_EN
        // Flat ADC in rising mode: only the timeout can trigger
        trig_mode = 2'b01; trig_level = 8'h80; adc_data = 8'h10; arm = 1'b1;
        step();
        arm = 1'b0;
        waited = 0;
        while (grant_acq !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        check("auto_trig_delay", waited, 16);
        check("auto_timed_out", timed_out, 1);
        finish_acq();
        done_rd = 1'b1;
        step();
        done_rd = 1'b0;
`else
        waited = 0;
        check("timed_out_tied", timed_out, waited);
`endif

        // Asynchronous reset mid-acquisition
        trig_mode = 2'b00; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        acq_wr_en = 1'b1; acq_wr_addr = 10'h155;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 1'b0; acq_wr_en = 1'b0;

        // Random soup against the model
        for (int i = 0; i < 3000; i++) begin
            arm         = ($urandom % 6) == 0;
            abort       = ($urandom % 50) == 0;
            if (($urandom % 64) == 0) continuous = $urandom;
            if (($urandom % 32) == 0) trig_mode = $urandom;
            if (($urandom % 64) == 0) trig_level = $urandom;
            adc_data    = $urandom;
            done_acq    = ($urandom % 5) == 0;
            acq_wr_en   = ($urandom % 3) == 0;
            acq_wr_addr = AW'($urandom);
            done_rd     = ($urandom % 7) == 0;
            rd_addr     = AW'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
